// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
// Owns the fetch PC and issues single-outstanding word reads on the instruction bus
// (req/gnt address phase, rvalid data phase). Returned words are buffered with their
// PCs in a small FIFO whose head is presented, registered, as IF_pc/IF_inst/IF_vld.
// Handshake: an IF entry is consumed on every cycle where IF_vld=1 and id_stall=0;
// a bus request is accepted on every cycle where imem_req=1 and imem_gnt=1.
// Optional feature macro: IF_PERF_CNT_EN adds the IF_fetch_cnt/IF_stall_cnt counters.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        id_stall,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] IF_fetch_cnt,
    output logic [31:0] IF_stall_cnt,
`endif
    output logic        IF_vld
);

    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic              imem_req_q, imem_req_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic [31:0]       pc_mem_q [FIFO_DEPTH];
    logic [31:0]       pc_mem_d [FIFO_DEPTH];
    logic [31:0]       inst_mem_q [FIFO_DEPTH];
    logic [31:0]       inst_mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       if_pc_q, if_pc_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic              if_vld_q, if_vld_d;

    logic [31:0]       redirect_tgt;
    logic              gnt_ok;
    logic              rvalid_ok;
    logic              push;
    logic              pop;
    logic              has_space;

    // Redirect targets are word aligned; low bits are dropped.
    assign redirect_tgt = ex_redirect_pc & ~32'h3;
    // A grant only counts while a request is actually on the bus.
    assign gnt_ok       = imem_req_q & imem_gnt;
    // Read data is only meaningful while a read is outstanding (WAIT or DROP).
    assign rvalid_ok    = imem_rvalid & ((state_q == WAIT) | (state_q == DROP));
    assign push         = rvalid_ok & (state_q == WAIT) & ~ex_redirect;
    assign pop          = if_vld_q & ~id_stall;
    // Slot check after this cycle's push/pop; the slot for a read is reserved at grant.
    assign has_space    = (count_d < CW'(FIFO_DEPTH));

    // Fetch buffer next state: flush on redirect, otherwise push/pop.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (ex_redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]   = req_pc_q;
                inst_mem_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Fetch FSM next state and PC bookkeeping; redirect overrides the fetch PC.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            IDLE: begin
                if (ex_redirect || has_space) state_d = REQ;
            end
            REQ: begin
                if (gnt_ok) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ex_redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (rvalid_ok) begin
                    state_d = (ex_redirect || has_space) ? REQ : IDLE;
                end else if (ex_redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (rvalid_ok) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
        if (ex_redirect) fetch_pc_d = redirect_tgt;
        imem_req_d  = (state_d == REQ);
        imem_addr_d = fetch_pc_d;
    end

    // Registered presentation of the buffer head after this cycle's updates.
    always_comb begin
        if_vld_d  = (count_d != '0);
        if_pc_d   = if_pc_q;
        if_inst_d = NOP;
        if (if_vld_d) begin
            if_pc_d   = pc_mem_d[rd_ptr_d];
            if_inst_d = inst_mem_d[rd_ptr_d];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            pc_mem_q    <= '{default: '0};
            inst_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            if_pc_q     <= '0;
            if_inst_q   <= NOP;
            if_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            pc_mem_q    <= pc_mem_d;
            inst_mem_q  <= inst_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            if_vld_q    <= if_vld_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign IF_pc     = if_pc_q;
    assign IF_inst   = if_inst_q;
    assign IF_vld    = if_vld_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Delivered-instruction and stalled-presentation counters, wrapping at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(pop);
        stall_cnt_d = stall_cnt_q + 32'(if_vld_q & id_stall);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign IF_fetch_cnt = fetch_cnt_q;
    assign IF_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized bench for if_stage with a memory responder, a PC-stream
// reference model feeding an expected queue, and a negedge monitor/scoreboard.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        id_stall;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;
    logic        IF_vld;
`ifdef IF_PERF_CNT_EN
    logic [31:0] IF_fetch_cnt;
    logic [31:0] IF_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int mode     = 0;   // 0: zero-wait, 1: random waits, 2: gnt withheld 3 cycles
    int pops_seen = 0;

    // Reference model: the instruction stream is consecutive words from the last
    // (re)start point; exp_q holds the PCs the DUT must deliver next, in order.
    logic [31:0] exp_q[$];
    logic [31:0] next_fill;
    int          fetch_exp;
    int          stall_exp;

    if_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .id_stall       (id_stall),
        .IF_pc          (IF_pc),
        .IF_inst        (IF_inst),
`ifdef IF_PERF_CNT_EN
        .IF_fetch_cnt   (IF_fetch_cnt),
        .IF_stall_cnt   (IF_stall_cnt),
`endif
        .IF_vld         (IF_vld)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_5A5B;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout @%0t", name, $time);
    endtask

    // Memory responder: grant policy by mode, one outstanding read, data = mem_fn(addr).
    logic        pending;
    logic [31:0] pend_addr;
    int          lat, hold_cnt, cur_delay;

    function automatic int pick_delay();
        if (mode == 1) return $urandom_range(0, 3);
        if (mode == 2) return 3;
        return 0;
    endfunction

    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        pending = 1'b0; pend_addr = '0; lat = 0; hold_cnt = 0; cur_delay = 0;
        forever begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (pending) begin
                if (lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_fn(pend_addr);
                end else begin
                    lat--;
                end
            end
            imem_gnt = imem_req && (hold_cnt >= cur_delay);
            @(negedge clk);
            if (imem_rvalid) pending = 1'b0;
            if (imem_req && imem_gnt) begin
                pending   = 1'b1;
                pend_addr = imem_addr;
                lat       = (mode == 1) ? $urandom_range(0, 2) : 0;
                hold_cnt  = 0;
                cur_delay = pick_delay();
            end else if (imem_req) begin
                hold_cnt++;
            end
            if (rst) begin
                hold_cnt  = 0;
                cur_delay = pick_delay();
            end
        end
    end

    // Monitor / scoreboard
    logic        prev_rst = 1'b1, prev_vld = 1'b0, prev_stall = 1'b0, prev_redir = 1'b0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [31:0] prev_pc = '0, prev_inst = '0, prev_addr = '0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            exp_q.delete();
            next_fill = RESET_PC;
            fetch_exp = 0;
            stall_exp = 0;
            prev_rst  = 1'b1;
        end else begin
`ifdef IF_PERF_CNT_EN
            check("fetch_cnt", IF_fetch_cnt, fetch_exp);
            check("stall_cnt", IF_stall_cnt, stall_exp);
`endif
            if (prev_redir) begin
                check("vld_after_redirect", IF_vld, 1'b0);
            end else if (!prev_rst && prev_vld && prev_stall) begin
                check("stall_hold_vld", IF_vld, 1'b1);
                check("stall_hold_pc", IF_pc, prev_pc);
                check("stall_hold_inst", IF_inst, prev_inst);
            end
            if (!IF_vld) begin
                check("empty_inst_nop", IF_inst, NOP);
                if (!prev_rst) check("empty_pc_hold", IF_pc, prev_pc);
            end
            if (IF_vld && !id_stall) begin
                e = exp_q.pop_front();
                check("deliver_pc", IF_pc, e);
                check("deliver_inst", IF_inst, mem_fn(e));
                pops_seen++;
                fetch_exp++;
            end
            if (IF_vld && id_stall) stall_exp++;
            if (imem_req) check("addr_align", imem_addr & 32'h3, 32'h0);
            if (!prev_rst && prev_req && !prev_gnt && !prev_redir) begin
                check("req_held", imem_req, 1'b1);
                check("addr_stable", imem_addr, prev_addr);
            end
            if (ex_redirect) begin
                exp_q.delete();
                next_fill = ex_redirect_pc & ~32'h3;
            end
            prev_rst = 1'b0;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_fill);
            next_fill = next_fill + 32'd4;
        end
        prev_vld   = IF_vld;
        prev_stall = id_stall;
        prev_redir = ex_redirect && !rst;
        prev_req   = imem_req;
        prev_gnt   = imem_gnt;
        prev_pc    = IF_pc;
        prev_inst  = IF_inst;
        prev_addr  = imem_addr;
    end

    // Driver tasks
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; ex_redirect = 1'b0; id_stall = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic redirect_in_wait(input logic [31:0] tgt, input logic stall);
        bit found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin found = 1; break; end
        end
        if (!found) begin
            timeout_fail("redirect_wait_gnt");
        end else begin
            @(posedge clk); #1;
            ex_redirect = 1'b1; ex_redirect_pc = tgt; id_stall = stall;
            @(posedge clk); #1;
            ex_redirect = 1'b0; id_stall = 1'b0;
            @(negedge clk);
            check("redirect_req_next", imem_req, 1'b1);
            check("redirect_addr", imem_addr, tgt & ~32'h3);
            @(negedge clk);
            @(negedge clk);
            check("redirect_vld_latency", IF_vld, 1'b1);
            check("redirect_first_pc", IF_pc, tgt & ~32'h3);
        end
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        int n;
        bit found;
        rst = 1'b1; ex_redirect = 1'b0; ex_redirect_pc = '0; id_stall = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_vld", IF_vld, 1'b0);
        check("reset_pc", IF_pc, 32'h0);
        check("reset_inst", IF_inst, NOP);
        check("reset_req", imem_req, 1'b0);
        check("reset_addr", imem_addr, RESET_PC);

        // Zero-wait memory: first request the cycle after reset, IF_vld every 2nd cycle from +3.
        mode = 0;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) check("first_req_low", imem_req, 1'b0);
            if (k == 1) begin
                check("first_req_high", imem_req, 1'b1);
                check("first_req_addr", imem_addr, RESET_PC);
            end
            if (k >= 1 && k <= 3) check("early_vld_low", IF_vld, (k == 3) ? 1'b1 : 1'b0);
            if (k >= 3) check("zero_wait_rate", IF_vld, (k % 2 == 1) ? 1'b1 : 1'b0);
        end

        // Grant withheld 3 cycles: request at 0x8 must hold address until granted.
        mode = 2;
        do_reset();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) begin found = 1; break; end
        end
        if (!found) begin
            timeout_fail("gnt_wait_find");
        end else begin
            n = 1;
            while (!imem_gnt && n < 10) begin
                @(negedge clk);
                check("gnt_wait_req", imem_req, 1'b1);
                check("gnt_wait_addr", imem_addr, 32'h8);
                n++;
            end
            check("gnt_wait_cycles", n, 4);
        end

        // Long stall: buffer fills, requests stop, head frozen; release drains in order.
        mode = 0;
        @(posedge clk); #1 id_stall = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_full_req_low", imem_req, 1'b0);
        check("stall_full_vld", IF_vld, 1'b1);
        @(posedge clk); #1 id_stall = 1'b0;
        repeat (10) @(posedge clk);

        // Redirects timed into WAIT (coincident with rvalid on zero-wait memory).
        redirect_in_wait(32'h0000_0103, 1'b0);
        repeat (6) @(posedge clk);
        redirect_in_wait(32'h0000_0202, 1'b1);
        repeat (6) @(posedge clk);

        // Randomized traffic with redirects, stalls, address wrap, and a mid-run reset.
        mode = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c == 1500) begin
                do_reset();
            end
            id_stall    = ($urandom_range(0, 2) == 0);
            ex_redirect = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                ex_redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else
                ex_redirect_pc = 32'($urandom_range(0, 4095));
        end
        @(posedge clk); #1;
        ex_redirect = 1'b0; id_stall = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pops_seen < 300) begin
            failures++;
            $display("FAIL delivery_count actual=%0d required>=300", pops_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
